// File: rtl/aline_readout_sequencer.sv
// A-line readout sequencer: drains completed ping-pong RAM banks into a valid/ready sample stream.
// Optional per-line header word is enabled with `define ALINE_HEADER_EN.
module aline_readout_sequencer #(
    parameter int                ADDR_W     = 11,
    parameter logic [ADDR_W-1:0] NSAMPLES   = 11'd1170,
    parameter int                DATA_W     = 16,
    parameter int                RD_LAT     = 2,
    parameter int                OBUF_DEPTH = 4
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              line_done,
    input  logic              wr_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic              overrun,
    output logic [1:0]        dbg_state
);

    // Stream handshake: a word transfers on any clock where out_valid & out_ready; while
    // out_valid=1 and out_ready=0 the word and its sop/eop flags are held unchanged.

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int PTR_W = $clog2(OBUF_DEPTH);
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
    localparam int ENT_W = DATA_W + 2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        q_cnt_q, q_cnt_d;
    logic [1:0]        q_bank_q, q_bank_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [RD_LAT-1:0] tag_q;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [ENT_W-1:0]  fifo_mem [OBUF_DEPTH];

    logic              tag_out, pop, done_now, start_line, line_active, push;
    logic              fifo_we, sop_flag, eop_flag;
    logic [1:0]        occupancy;
    logic [CNT_W:0]    credit_sum;
    logic [ENT_W-1:0]  head_ent, wr_ent;

    assign tag_out    = tag_q[RD_LAT-1];
    assign head_ent   = fifo_mem[rd_ptr_q];
    assign out_valid  = (fifo_cnt_q != '0);
    assign out_data   = out_valid ? head_ent[DATA_W-1:0] : '0;
    assign out_sop    = out_valid & head_ent[DATA_W];
    assign out_eop    = out_valid & head_ent[DATA_W+1];
    assign pop        = out_valid & out_ready;

    // Words already buffered plus reads still in the RAM pipeline may never exceed the FIFO.
    assign credit_sum = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign rd_en      = (state_q == S_READ) && (credit_sum < (CNT_W+1)'(OBUF_DEPTH));

    assign done_now   = (state_q == S_DRAIN) && (inflight_q == '0) && pop && out_eop;
    assign start_line = (q_cnt_q != 2'd0) && ((state_q == S_IDLE) || done_now);

    // The bank being read still holds RAM, so it counts against the two-bank capacity.
    assign line_active = (state_q != S_IDLE) && !done_now;
    assign occupancy   = q_cnt_q + {1'b0, line_active};
    assign push        = line_done && (occupancy < 2'd2);

    assign sop_flag = (wr_idx_q == '0);
    assign eop_flag = (wr_idx_q == NSAMPLES);

`ifdef ALINE_HEADER_EN
    logic [DATA_W-2:0] line_cnt_q;

    // Header enters the FIFO on the clock the line starts; the RAM pipeline is empty then.
    assign fifo_we = tag_out | start_line;
    assign wr_ent  = start_line ? {2'b01, line_cnt_q, q_bank_q[0]}
                                : {eop_flag, 1'b0, rd_data};

    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) line_cnt_q <= '0;
        else if (start_line) line_cnt_q <= line_cnt_q + 1'b1;
    end
`else
    assign fifo_we = tag_out;
    assign wr_ent  = {eop_flag, sop_flag, rd_data};
`endif

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        case (state_q)
            S_READ: begin
                if (rd_en) begin
                    if (rd_addr_q == NSAMPLES) state_d   = S_DRAIN;
                    else                       rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (done_now) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (start_line) begin
            state_d   = S_READ;
            rd_bank_d = q_bank_q[0];
            rd_addr_d = '0;
        end
    end

    always_comb begin
        q_cnt_d  = q_cnt_q;
        q_bank_d = q_bank_q;
        case ({push, start_line})
            2'b10: begin
                q_bank_d[q_cnt_q[0]] = wr_bank;
                q_cnt_d              = q_cnt_q + 2'd1;
            end
            2'b01: begin
                q_bank_d = {1'b0, q_bank_q[1]};
                q_cnt_d  = q_cnt_q - 2'd1;
            end
            2'b11: begin
                q_bank_d[0] = (q_cnt_q == 2'd2) ? q_bank_q[1] : wr_bank;
                q_bank_d[1] = wr_bank;
            end
            default: ;
        endcase
        overrun_d = overrun_q | (line_done & ~push);
    end

    always_comb begin
        inflight_d = inflight_q + CNT_W'(rd_en) - CNT_W'(tag_out);
        wr_idx_d   = wr_idx_q;
        if (tag_out) wr_idx_d = eop_flag ? '0 : wr_idx_q + 1'b1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (fifo_we) wr_ptr_d = (wr_ptr_q == PTR_W'(OBUF_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = (rd_ptr_q == PTR_W'(OBUF_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_we) - CNT_W'(pop);
    end

    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            rd_bank_q  <= 1'b0;
            q_cnt_q    <= 2'd0;
            q_bank_q   <= 2'b00;
            overrun_q  <= 1'b0;
            inflight_q <= '0;
            tag_q      <= '0;
            wr_idx_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rd_bank_q  <= rd_bank_d;
            q_cnt_q    <= q_cnt_d;
            q_bank_q   <= q_bank_d;
            overrun_q  <= overrun_d;
            inflight_q <= inflight_d;
            tag_q[0]   <= rd_en;
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            wr_idx_q   <= wr_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (fifo_we) fifo_mem[wr_ptr_q] <= wr_ent;
    end

    assign rd_addr   = rd_addr_q;
    assign rd_bank   = rd_bank_q;
    assign busy      = (state_q != S_IDLE) || (q_cnt_q != 2'd0);
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: doc/aline_readout_sequencer.md
Name: aline_readout_sequencer

Overview:
- Read side of the A-line acquisition buffer.
- The sample write-address counter fills one bank of a two-bank (ping-pong) sample RAM with NSAMPLES+1 samples (addresses 0..NSAMPLES) per A-line.
- This block takes each completed bank, generates read addresses and read enables, compensates for RAM read latency, and streams the samples downstream over a valid/ready interface with start-of-packet and end-of-packet markers.
- It sits between the dual-port acquisition RAM and the transfer FIFO feeding the host link.

Parameters:
NSAMPLES, 11'd1170, last sample address of an A-line; line length = NSAMPLES+1 words
ADDR_W, 11, RAM address width
DATA_W, 16, sample width
RD_LAT, 2, RAM read latency in clocks (rd_en to rd_data valid), legal 1..3
OBUF_DEPTH, 4, output skid FIFO depth; must be >= RD_LAT+2

Ports:
clock  in  1  sample/system clock, rising edge
sclr  in  1  reset, asynchronous, active-high
line_done  in  1  one-clock pulse: write side finished a line
wr_bank  in  1  bank just completed, sampled with line_done
rd_addr  out  ADDR_W  RAM read address
rd_bank  out  1  RAM bank select for reads
rd_en  out  1  RAM read enable
rd_data  in  DATA_W  RAM read data, valid RD_LAT clocks after rd_en
out_data  out  DATA_W  stream data
out_valid  out  1  stream valid
out_ready  in  1  downstream ready
out_sop  out  1  first word of line, qualified by out_valid
out_eop  out  1  last word of line, qualified by out_valid
busy  out  1  line pending or in transfer
overrun  out  1  sticky: line_done dropped (both banks pending)

Behaviour:
- Reset (async, sclr=1): state IDLE; rd_addr=0, rd_en=0, rd_bank=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, busy=0, overrun=0; pending queue, output FIFO and in-flight counter cleared. Reset mid-line aborts the line with no eop; first line after release starts with sop.
- Pending queue: 2 entries of bank IDs, FIFO order.
  - line_done pushes wr_bank.
  - line_done while queue full: discard, set overrun (cleared only by sclr).
  - Push and pop in the same clock are both honoured.
- States:
  - IDLE: queue non-empty -> pop bank into rd_bank, rd_addr=0 -> READ.
  - READ: assert rd_en when (fifo_count + inflight) < OBUF_DEPTH. Each rd_en increments rd_addr. At rd_addr==NSAMPLES with rd_en -> DRAIN; rd_addr holds at NSAMPLES, never wraps.
  - DRAIN: wait until inflight==0 and last word accepted (out_valid & out_ready & out_eop) -> IDLE, or directly to READ with the next popped bank if the queue is non-empty (no idle clock required).
- Latency: delay line of RD_LAT stages carries the valid tag; rd_data is written into the output FIFO on tag arrival. First out_valid occurs RD_LAT+1 clocks after first rd_en.
- Output FIFO: first-word-fall-through.
  - out_sop set on word index 0; out_eop set on index NSAMPLES.
  - Word index is tracked with the data, not derived from rd_addr.
  - Holding rule: out_data, out_sop and out_eop stay stable while out_valid=1 and out_ready=0. The FIFO never overflows; the credit rule above guarantees this.
- Throughput: with out_ready held high, one word per clock; line of 1171 words completes in 1171+RD_LAT+1 clocks.
- busy = (state != IDLE) | queue non-empty.
- Width rules: word index counter ADDR_W bits; compare against NSAMPLES exactly (count 0..NSAMPLES inclusive).

Optional Feature:
- ALINE_HEADER_EN defined:
  - Each line is preceded by one header word: {line_count[DATA_W-2:0], rd_bank}.
  - line_count is a free-running counter, 0 after reset, increments per line started, and wraps.
  - The header word carries out_sop; sample 0 does not.
  - Packet length = NSAMPLES+2.
- Not defined: no header; the sop/eop rules above apply.

Test Plan:
- Reset, one line_done (wr_bank=1), out_ready=1 -> rd_bank=1, 1171 rd_en pulses at addresses 0..1170, 1171 out words matching RAM contents, sop on word 0, eop on word 1170, busy low afterwards.
- Same line with out_ready toggled 1-0 every clock, and a 50-clock stall mid-line -> no lost or duplicated words, data stable while stalled, credit count never exceeded.
- Two line_done pulses (banks 0, 1) 10 clocks apart, then a third before the first finishes -> banks 0 then 1 streamed back to back, overrun=1 after the third, third line absent.
- sclr asserted at word 500 of a line -> all outputs at reset values immediately; next line_done gives a clean line with sop.
- RD_LAT=1 and RD_LAT=3 builds, out_ready=1 -> first out_valid at 2 and 4 clocks after first rd_en respectively; full-rate streaming.
- ALINE_HEADER_EN build, three lines -> header words 0x0000|bank, 0x0002|bank, 0x0004|bank, sop on header, 1172 words per line.
